dac_dual_buffer: RTL and testbench



---
 rtl/dac_dual_buffer.sv | 196 +++++++++++++++++++
 tb/tb_dac_dual_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_dual_buffer.sv
// Ping-pong sample buffer from the FSMC bus to a parallel DAC, one sample per DIV clk.
// Bus ops take effect <=4 clk after an en edge; no backpressure, so an empty next buffer raises underrun.
module dac_dual_buffer #(
  parameter int          DATA_WIDTH  = 12,
  parameter int          BUF_SIZE    = 1024,
  parameter int          DIV         = 20,
  parameter logic [15:0] CTRL_ADDR   = 16'h4000,
  parameter logic [15:0] STATUS_ADDR = 16'h4001,
  parameter logic [15:0] COMMIT_ADDR = 16'h4002
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  state,
  input  logic [15:0]           rd_data,
  output logic [15:0]           wr_data,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_valid
);

  localparam int              AW      = $clog2(BUF_SIZE);
  localparam int              CW      = $clog2(DIV);
  localparam logic [16:0]     BUF_LIM = 17'(BUF_SIZE);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
  localparam logic [AW-1:0]   PTR_MAX = AW'(BUF_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUF, PLAY} fsm_t;

  logic                  en_s1_q, en_s2_q, en_s3_q;
  logic [15:0]           addr_q;
  logic                  dir_q;
  logic                  rd_pend_q;
  logic [15:0]           wr_data_q;
  logic                  run_q, loop_q;
  logic                  underrun_q, underrun_d;
  logic [1:0]            committed_q, committed_d;
  logic                  fill_buf_q, fill_buf_d;
  logic                  play_buf_q, play_buf_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  fsm_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0] dac_data_q;
  logic                  dac_valid_q;

  logic [DATA_WIDTH-1:0] mem_q [2*BUF_SIZE];
  logic [DATA_WIDTH-1:0] bus_ram_q;
  logic [DATA_WIDTH-1:0] play_ram_q;

  logic        bus_rise, bus_fall;
  logic        addr_in_buf;
  logic        wr_buf, wr_ctrl, commit_ok;
  logic        tick, dac_upd, other_ready, playing, fill_ready;
  logic [15:0] rd_val;

  assign bus_rise    = en_s2_q & ~en_s3_q;
  assign bus_fall    = ~en_s2_q & en_s3_q & ~dir_q;
  assign addr_in_buf = ({1'b0, addr_q} < BUF_LIM);
  assign wr_buf      = bus_fall & addr_in_buf & ~committed_q[fill_buf_q];
  assign wr_ctrl     = bus_fall & (addr_q == CTRL_ADDR);
  assign commit_ok   = bus_fall & (addr_q == COMMIT_ADDR) & ~committed_q[fill_buf_q];

  assign tick       = run_q & (cnt_q == CNT_MAX);
  assign cnt_d      = (!run_q || tick) ? '0 : cnt_q + CW'(1);
  assign playing    = (state_q == PLAY);
  assign fill_ready = ~committed_q[fill_buf_q];

  // Both read ports are registered every cycle; the player port always tracks {play_buf, ptr},
  // so the sample for the next tick is settled long before that tick arrives.
  always_ff @(posedge clk) begin
    if (wr_buf) begin
      mem_q[{fill_buf_q, addr_q[AW-1:0]}] <= rd_data[DATA_WIDTH-1:0];
    end
    bus_ram_q  <= mem_q[{fill_buf_q, rd_data[AW-1:0]}];
    play_ram_q <= mem_q[{play_buf_q, ptr_q}];
  end

  always_comb begin
    rd_val = 16'h0000;
    if (addr_in_buf) begin
      rd_val = 16'(bus_ram_q);
    end else if (addr_q == CTRL_ADDR) begin
      rd_val = {14'b0, loop_q, run_q};
    end else if (addr_q == STATUS_ADDR) begin
      rd_val = {12'b0, play_buf_q, underrun_q, playing, fill_ready};
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    play_buf_d  = play_buf_q;
    fill_buf_d  = fill_buf_q;
    committed_d = committed_q;
    underrun_d  = underrun_q;
    dac_upd     = 1'b0;
    // A commit landing on the end-of-buffer cycle already counts as a ready next buffer.
    other_ready = committed_q[~play_buf_q] | (commit_ok & (fill_buf_q != play_buf_q));

    if (wr_ctrl && rd_data[2]) begin
      underrun_d = 1'b0;
    end
    if (commit_ok) begin
      committed_d[fill_buf_q] = 1'b1;
      fill_buf_d              = ~fill_buf_q;
    end

    if (!run_q) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_BUF;
        WAIT_BUF: begin
          if (committed_q[play_buf_q]) begin
            state_d = PLAY;
            ptr_d   = '0;
          end
        end
        PLAY: begin
          if (tick) begin
            dac_upd = 1'b1;
            if (ptr_q == PTR_MAX) begin
              ptr_d = '0;
              if (!(loop_q && !other_ready)) begin
                committed_d[play_buf_q] = 1'b0;
                play_buf_d              = ~play_buf_q;
                if (!other_ready) begin
                  underrun_d = 1'b1;
                  state_d    = WAIT_BUF;
                end
              end
            end else begin
              ptr_d = ptr_q + AW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1_q     <= 1'b0;
      en_s2_q     <= 1'b0;
      en_s3_q     <= 1'b0;
      addr_q      <= 16'h0000;
      dir_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_data_q   <= 16'h0000;
      run_q       <= 1'b0;
      loop_q      <= 1'b0;
      underrun_q  <= 1'b0;
      committed_q <= 2'b00;
      fill_buf_q  <= 1'b0;
      play_buf_q  <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
    end else begin
      en_s1_q <= en;
      en_s2_q <= en_s1_q;
      en_s3_q <= en_s2_q;
      if (bus_rise) begin
        addr_q <= rd_data;
        dir_q  <= state;
      end
      rd_pend_q <= bus_rise & state;
      if (rd_pend_q) begin
        wr_data_q <= rd_val;
      end
      if (wr_ctrl) begin
        run_q  <= rd_data[0];
        loop_q <= rd_data[1];
      end
      underrun_q  <= underrun_d;
      committed_q <= committed_d;
      fill_buf_q  <= fill_buf_d;
      play_buf_q  <= play_buf_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      dac_valid_q <= dac_upd;
      if (dac_upd) begin
        dac_data_q <= play_ram_q;
      end
    end
  end

  assign wr_data   = wr_data_q;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;

endmodule

// File: tb/tb_dac_dual_buffer.sv
// Directed bench for dac_dual_buffer with small buffers; a monitor logs every DAC sample and its cycle.
module tb_dac_dual_buffer;

  localparam int          DW   = 12;
  localparam int          BS   = 16;
  localparam int          DV   = 20;
  localparam logic [15:0] CTRL = 16'h4000;
  localparam logic [15:0] STAT = 16'h4001;
  localparam logic [15:0] CMT  = 16'h4002;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          state;
  logic [15:0]   rd_data;
  logic [15:0]   wr_data;
  logic [DW-1:0] dac_data;
  logic          dac_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] sq[$];
  int            tq[$];

  dac_dual_buffer #(
    .DATA_WIDTH(DW), .BUF_SIZE(BS), .DIV(DV),
    .CTRL_ADDR(CTRL), .STATUS_ADDR(STAT), .COMMIT_ADDR(CMT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .state(state), .rd_data(rd_data),
    .wr_data(wr_data), .dac_data(dac_data), .dac_valid(dac_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && dac_valid) begin
      sq.push_back(dac_data);
      tq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    rd_data = a; state = 1'b0; en = 1'b1;
    clks(5);
    rd_data = d;
    clks(2);
    en = 1'b0;
    clks(6);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    rd_data = a; state = 1'b1; en = 1'b1;
    clks(8);
    en = 1'b0;
    clks(4);
    state = 1'b0;
    d = wr_data;
  endtask

  task automatic fill(input int off);
    for (int i = 0; i < BS; i++) bus_wr(16'(i), 16'(i + off));
  endtask

  task automatic wait_n(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && sq.size() < n; k++) clks(1);
    chk(tag, sq.size(), n);
  endtask

  task automatic chk_gaps(input string tag);
    for (int j = 1; j < tq.size(); j++) chk(tag, tq[j] - tq[j-1], DV);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(2);
  endtask

  logic [15:0] rv;
  int          n0;

  initial begin
    rst_n = 1'b0; en = 1'b0; state = 1'b0; rd_data = 16'h0000;
    clks(3);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    clks(2);

    // 1: single buffer, then underrun
    bus_rd(CTRL, rv);  chk("t1_ctrl_rst", rv, 16'h0);
    fill(10);
    bus_wr(CMT, 16'h0);
    bus_rd(STAT, rv);  chk("t1_stat_commit", rv, 16'h1);
    sq.delete(); tq.delete();
    bus_wr(CTRL, 16'h1);
    bus_rd(STAT, rv);  chk("t1_stat_play", rv, 16'h3);
    wait_n(BS, BS*DV + 200, "t1_count");
    for (int j = 0; j < BS && j < sq.size(); j++) chk("t1_val", sq[j], 10 + j);
    chk_gaps("t1_gap");
    clks(60);
    chk("t1_no_extra", sq.size(), BS);
    bus_rd(STAT, rv);  chk("t1_stat_underrun", rv, 16'hD);
    chk("t1_hold", dac_data, 10 + BS - 1);

    // 2: ping-pong, refill buf0 while buf1 plays
    do_reset();
    fill(10);  bus_wr(CMT, 16'h0);
    fill(20);  bus_wr(CMT, 16'h0);
    sq.delete(); tq.delete();
    bus_wr(CTRL, 16'h1);
    wait_n(BS, BS*DV + 200, "t2_first");
    fill(30);  bus_wr(CMT, 16'h0);
    wait_n(2*BS + 8, 2*BS*DV, "t2_mid");
    bus_rd(STAT, rv);  chk("t2_stat_mid", rv, 16'h3);
    wait_n(3*BS, 2*BS*DV, "t2_count");
    for (int j = 0; j < 3*BS && j < sq.size(); j++)
      chk("t2_val", sq[j], (j / BS) * 10 + 10 + (j % BS));
    chk_gaps("t2_gap");

    // 3: loop over one buffer
    do_reset();
    fill(10);  bus_wr(CMT, 16'h0);
    sq.delete(); tq.delete();
    bus_wr(CTRL, 16'h3);
    wait_n(3*BS + 1, 4*BS*DV, "t3_count");
    for (int j = 0; j < 3*BS + 1 && j < sq.size(); j++) chk("t3_val", sq[j], 10 + (j % BS));
    chk_gaps("t3_gap");
    bus_rd(STAT, rv);  chk("t3_stat", rv, 16'h3);

    // 4: overflow, both buffers committed
    do_reset();
    fill(10);  bus_wr(CMT, 16'h0);
    fill(20);  bus_wr(CMT, 16'h0);
    bus_rd(STAT, rv);  chk("t4_stat_full", rv, 16'h0);
    bus_wr(CMT, 16'h0);
    bus_wr(16'h0000, 16'h0777);
    bus_rd(16'h0000, rv); chk("t4_rd_addr0", rv, 16'd10);
    bus_rd(STAT, rv);  chk("t4_stat_after", rv, 16'h0);
    bus_rd(16'h1234, rv); chk("t4_rd_other", rv, 16'h0);

    // 5: stop mid-buffer, restart, underrun clear
    sq.delete(); tq.delete();
    bus_wr(CTRL, 16'h1);
    wait_n(5, 10*DV, "t5_start");
    bus_wr(CTRL, 16'h0);
    n0 = sq.size();
    chk("t5_stop_soon", 32'(n0 <= 6), 1);
    clks(100);
    chk("t5_stopped", sq.size(), n0);
    bus_rd(STAT, rv);  chk("t5_stat_stop", rv, 16'h0);
    sq.delete(); tq.delete();
    bus_wr(CTRL, 16'h1);
    wait_n(2*BS, 3*BS*DV, "t5_count");
    for (int j = 0; j < 2*BS && j < sq.size(); j++)
      chk("t5_val", sq[j], (j < BS) ? 10 + j : 20 + (j - BS));
    chk_gaps("t5_gap");
    clks(40);
    bus_rd(STAT, rv);  chk("t5_stat_underrun", rv, 16'h5);
    bus_wr(CTRL, 16'h5);
    bus_rd(STAT, rv);  chk("t5_stat_clear", rv, 16'h1);
    bus_rd(CTRL, rv);  chk("t5_ctrl_rd", rv, 16'h1);

    // 6: asynchronous reset mid-playback
    fill(40);
    sq.delete(); tq.delete();
    bus_wr(CMT, 16'h0);
    wait_n(3, 5*DV, "t6_start");
    chk("t6_first", sq.size() > 0 ? 32'(sq[0]) : 32'hFFFF, 40);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_dac_data", dac_data, 0);
    chk("t6_dac_valid", dac_valid, 0);
    chk("t6_wr_data", wr_data, 0);
    clks(3);
    rst_n = 1'b1;
    sq.delete(); tq.delete();
    clks(100);
    chk("t6_quiet", sq.size(), 0);
    bus_wr(CTRL, 16'h1);
    clks(100);
    chk("t6_quiet_run", sq.size(), 0);
    bus_wr(CMT, 16'h0);
    wait_n(1, 3*DV, "t6_restart");
    chk("t6_ram_kept", sq.size() > 0 ? 32'(sq[0]) : 32'hFFFF, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
